eq_mac_sched: RTL and testbench

Scheduler that time-shares one signed 16x16 multiply-accumulator across all equalizer bands and FIR taps for each audio sample. On every accepted sample it writes a circular sample window, then steps through band/tap pairs. It issues coefficient-memory addresses, applies a per-band 8-bit gain and emits one filtered 16-bit sample. It sits between the I2S receiver (sample source) and the SPI-loaded gain register/output path, on the 24 MHz HSOSC clock.

---
 rtl/eq_mac_sched.sv | 189 ++++++++++++++++++
 tb/tb_eq_mac_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_mac_sched.sv
// Equalizer MAC scheduler: one signed 16x16 MAC shared by every band/tap pair of each sample.
// Define EQ_SCHED_SAT_EN to clamp the output to 16 bits; otherwise the total wraps.
module eq_mac_sched #(
    parameter int NTAPS  = 10,
    parameter int NBANDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_i,
    input  logic        sample_valid,
    input  logic [31:0] gains,
    output logic [7:0]  coef_addr,
    input  logic [15:0] coef_data,
    output logic [15:0] result_o,
    output logic        result_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int TW = $clog2(NTAPS);
    localparam int BW = (NBANDS > 1) ? $clog2(NBANDS) : 1;
    localparam logic [TW-1:0] LAST_TAP  = TW'(NTAPS - 1);
    localparam logic [BW-1:0] LAST_BAND = BW'(NBANDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_GAIN, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      tap_q, tap_d;
    logic [BW-1:0]      band_q, band_d;
    logic [TW-1:0]      wp_q, wp_d;
    logic [TW-1:0]      rp_q, rp_d;
    logic signed [15:0] window_q [NTAPS];
    logic signed [15:0] window_d [NTAPS];
    logic signed [39:0] acc_q, acc_d;
    logic signed [47:0] total_q, total_d;
    logic [31:0]        gains_q, gains_d;
    logic [7:0]         coef_addr_q, coef_addr_d;
    logic [15:0]        result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               overrun_q, overrun_d;

    logic               busy_c;
    logic               accept;
    logic               mac_en;
    logic signed [31:0] product;
    logic [7:0]         gain_sel;
    logic signed [47:0] band_ext;
    logic signed [47:0] gain_ext;
    logic signed [47:0] gained;
    logic signed [47:0] scaled;
    logic [15:0]        result_sat;

    // OUT is not busy, so a sample arriving while the result is written starts the next run.
    assign busy_c = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_GAIN);
    assign accept = sample_valid && !busy_c;
    assign mac_en = ((state_q == S_RUN) && (tap_q != '0)) || (state_q == S_DRAIN);

    // rp_q walks backwards from the newest sample, one step per MAC, and wraps back each band.
    assign product  = 32'($signed(coef_data)) * 32'(window_q[rp_q]);
    assign gain_sel = gains_q[{band_q, 3'b000} +: 8];
    assign band_ext = 48'(acc_q >>> 15);
    assign gain_ext = {40'd0, gain_sel};
    assign gained   = band_ext * gain_ext;
    assign scaled   = gained >>> 7;

    always_comb begin
`ifdef EQ_SCHED_SAT_EN
        if (total_q > 48'sd32767) begin
            result_sat = 16'h7FFF;
        end else if (total_q < -48'sd32768) begin
            result_sat = 16'h8000;
        end else begin
            result_sat = total_q[15:0];
        end
`else
        result_sat = total_q[15:0];
`endif
    end

    // NOTE: every _d gets its current value first, so no path through this block can infer a latch.
    always_comb begin
        state_d        = state_q;
        tap_d          = tap_q;
        band_d         = band_q;
        wp_d           = wp_q;
        rp_d           = rp_q;
        window_d       = window_q;
        acc_d          = acc_q;
        total_d        = total_q;
        gains_d        = gains_q;
        coef_addr_d    = coef_addr_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        overrun_d      = overrun_q;

        if (mac_en) begin
            acc_d = acc_q + 40'(product);
            rp_d  = (rp_q == '0) ? LAST_TAP : rp_q - TW'(1);
        end

        case (state_q)
            S_RUN: begin
                if (tap_q == LAST_TAP) begin
                    state_d = S_DRAIN;
                end else begin
                    tap_d       = tap_q + TW'(1);
                    coef_addr_d = coef_addr_q + 8'd1;
                end
            end
            S_DRAIN: state_d = S_GAIN;
            S_GAIN: begin
                total_d = total_q + scaled;
                acc_d   = '0;
                if (band_q == LAST_BAND) begin
                    band_d  = '0;
                    state_d = S_OUT;
                end else begin
                    band_d      = band_q + BW'(1);
                    tap_d       = '0;
                    coef_addr_d = 8'((32'(band_q) + 32'd1) * NTAPS);
                    state_d     = S_RUN;
                end
            end
            S_OUT: begin
                result_d       = result_sat;
                result_valid_d = 1'b1;
                total_d        = '0;
                state_d        = S_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            window_d[wp_q] = sample_i;
            wp_d           = (wp_q == LAST_TAP) ? '0 : wp_q + TW'(1);
            rp_d           = wp_q;
            gains_d        = gains;
            band_d         = '0;
            tap_d          = '0;
            coef_addr_d    = '0;
            state_d        = S_RUN;
        end else if (sample_valid) begin
            overrun_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            tap_q          <= '0;
            band_q         <= '0;
            wp_q           <= '0;
            rp_q           <= '0;
            acc_q          <= '0;
            total_q        <= '0;
            gains_q        <= '0;
            coef_addr_q    <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            // NOTE: the window is cleared on reset so a restarted stream never filters stale samples.
            for (int i = 0; i < NTAPS; i++) begin
                window_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            tap_q          <= tap_d;
            band_q         <= band_d;
            wp_q           <= wp_d;
            rp_q           <= rp_d;
            window_q       <= window_d;
            acc_q          <= acc_d;
            total_q        <= total_d;
            gains_q        <= gains_d;
            coef_addr_q    <= coef_addr_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign coef_addr    = coef_addr_q;
    assign result_o     = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_c;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_eq_mac_sched.sv
// Scoreboard bench for eq_mac_sched: a behavioural filter model predicts each result at accept time.
// Honours EQ_SCHED_SAT_EN the same way the design does.
`timescale 1ns/1ps
module tb_eq_mac_sched;

    localparam int NT  = 10;
    localparam int NB  = 4;
    localparam int LAT = NB * (NT + 2) + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_i = '0;
    logic        sample_valid = 1'b0;
    logic [31:0] gains = '0;
    logic [7:0]  coef_addr;
    logic [15:0] coef_data = '0;
    logic [15:0] result_o;
    logic        result_valid;
    logic        busy;
    logic        overrun;

    eq_mac_sched #(.NTAPS(NT), .NBANDS(NB)) dut (
        .clk(clk), .reset(reset), .sample_i(sample_i), .sample_valid(sample_valid),
        .gains(gains), .coef_addr(coef_addr), .coef_data(coef_data), .result_o(result_o),
        .result_valid(result_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Synchronous-read coefficient ROM: data follows the address by one cycle.
    logic signed [15:0] coef_mem [256];
    always @(posedge clk) coef_data <= coef_mem[coef_addr];

    typedef struct {
        logic [15:0] val;
        longint      t;
    } exp_t;

    exp_t               sb[$];
    logic signed [15:0] xw [NT];
    int                 wpm = 0;
    int                 busy_cnt = 0;
    bit                 ovr_m = 1'b0;
    int                 n_cmp = 0;
    int                 n_err = 0;
    int                 n_results = 0;
    logic [15:0]        last_result = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_result(input logic [31:0] g);
        longint total, acc, bv, gg;
        int idx;
        total = 0;
        for (int b = 0; b < NB; b++) begin
            acc = 0;
            for (int k = 0; k < NT; k++) begin
                idx = (wpm - 1 - k + 2 * NT) % NT;
                acc += longint'(coef_mem[b * NT + k]) * longint'(xw[idx]);
            end
            bv = acc >>> 15;
            gg = longint'(g[8 * b +: 8]);
            total += (bv * gg) >>> 7;
        end
`ifdef EQ_SCHED_SAT_EN
        if (total > 32767) return 16'h7FFF;
        if (total < -32768) return 16'h8000;
`endif
        return total[15:0];
    endfunction

    task automatic accept_model(input logic [15:0] s);
        exp_t e;
        xw[wpm] = s;
        wpm = (wpm + 1) % NT;
        e.val = model_result(gains);
        e.t = longint'($time);
        sb.push_back(e);
    endtask

    // One cycle of stimulus; the bench's own busy/overrun model is compared every cycle.
    task automatic step(input logic v, input logic [15:0] s);
        @(negedge clk);
        if (busy_cnt > 0) busy_cnt--;
        check("busy", busy, busy_cnt != 0);
        check("overrun", overrun, ovr_m);
        sample_valid = v;
        sample_i = s;
        if (v) begin
            if (busy_cnt == 0) begin
                accept_model(s);
                busy_cnt = LAT - 1;
            end else begin
                ovr_m = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sample_valid = 1'b1;
        sample_i = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sample_valid = 1'b0;
        busy_cnt = 0;
        ovr_m = 1'b0;
        sb.delete();
        wpm = 0;
        for (int i = 0; i < NT; i++) xw[i] = '0;
        check("rst_result_o", result_o, 16'h0);
        check("rst_result_valid", result_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_coef_addr", coef_addr, 8'h0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && busy_cnt == 0) break;
            step(1'b0, 16'h0);
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    task automatic clear_coefs();
        for (int i = 0; i < 256; i++) coef_mem[i] = '0;
    endtask

    always @(negedge clk) begin
        if (result_valid) begin
            n_results++;
            last_result = result_o;
            if (sb.size() == 0) begin
                check("unexpected_result_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result_o, e.val);
                check("latency", (longint'($time) - e.t) / 10, LAT);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int c;
        clear_coefs();
        for (int i = 0; i < NT; i++) xw[i] = '0;

        do_reset();

        // Impulse through band 0 tap 0, with the address sequence of all four bands.
        coef_mem[0] = 16'sh7FFF;
        gains = 32'h0000_0080;
        step(1'b1, 16'h4000);
        for (int k = 1; k <= 48; k++) begin
            step(1'b0, 16'h0);
            c = k - 1;
            check($sformatf("coef_addr_c%0d", c), coef_addr,
                  (c / 12) * NT + (((c % 12) < NT) ? (c % 12) : NT - 1));
        end
        wait_done();
        check("impulse_value", last_result, 16'h3FFF);
        check("coef_addr_hold", coef_addr, 8'd39);

        // Oldest-tap coefficient exposes the circular window wrap.
        do_reset();
        clear_coefs();
        coef_mem[NT - 1] = 16'sh7FFF;
        for (int i = 1; i <= 11; i++) begin
            step(1'b1, 16'(100 * i));
            repeat (99) step(1'b0, 16'h0);
            check($sformatf("wrap_s%0d", i), last_result,
                  (i < 10) ? 16'd0 : ((i == 10) ? 16'd99 : 16'd199));
        end

        // A sample arriving mid-run is dropped and flagged.
        do_reset();
        clear_coefs();
        coef_mem[0] = 16'sh7FFF;
        coef_mem[1] = 16'sh4000;
        n0 = n_results;
        step(1'b1, 16'd1000);
        repeat (9) step(1'b0, 16'h0);
        step(1'b1, 16'd5000);
        wait_done();
        check("overrun_one_result", n_results - n0, 1);
        check("overrun_value", last_result, 16'd999);
        repeat (30) step(1'b0, 16'h0);
        check("overrun_sticky", overrun, 1'b1);
        step(1'b1, 16'd2000);
        wait_done();
        check("overrun_window", last_result, 16'd2499);

        // Reset in the middle of a run abandons it; a sample during reset is ignored.
        step(1'b1, 16'd3000);
        repeat (20) step(1'b0, 16'h0);
        do_reset();
        n0 = n_results;
        repeat (80) step(1'b0, 16'h0);
        check("no_result_after_reset", n_results - n0, 0);

        // Two full-scale samples on two full-scale taps.
        clear_coefs();
        coef_mem[0] = 16'sh7FFF;
        coef_mem[1] = 16'sh7FFF;
        step(1'b1, 16'h7FFF);
        wait_done();
        check("sat_first", last_result, 16'h7FFE);
        step(1'b1, 16'h7FFF);
        wait_done();
`ifdef EQ_SCHED_SAT_EN
        check("sat_second", last_result, 16'h7FFF);
`else
        check("sat_second", last_result, 16'hFFFC);
`endif
        step(1'b1, 16'h8000);
        wait_done();
        step(1'b1, 16'h8000);
        wait_done();

        // Gains are snapshotted at accept.
        do_reset();
        clear_coefs();
        coef_mem[0] = 16'sh7FFF;
        gains = 32'h0000_0080;
        step(1'b1, 16'h4000);
        repeat (5) step(1'b0, 16'h0);
        gains = 32'h0000_0040;
        wait_done();
        check("gain_snapshot_cur", last_result, 16'h3FFF);
        step(1'b1, 16'h4000);
        wait_done();
        check("gain_snapshot_next", last_result, 16'h1FFF);
        step(1'b1, 16'hC000);
        wait_done();
        check("gain_negative_floor", last_result, 16'hE000);

        // Random coefficients on all bands with sample_valid held high: accepts land on OUT cycles.
        for (int i = 0; i < NB * NT; i++) coef_mem[i] = 16'($urandom);
        gains = 32'h20C0_80FF;
        for (int i = 0; i < 200; i++) step(1'b1, 16'($urandom));
        step(1'b0, 16'h0);
        wait_done();
        check("stream_overrun", overrun, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
